// File: rtl/mips_core_pkg.sv
// Shared front-end types: the fetch-queue entry and its default depth.
package mips_core_pkg;

  localparam int unsigned FETCH_BUF_DEPTH  = 4;
  localparam int unsigned FETCH_ADDR_WIDTH = 32;
  localparam int unsigned FETCH_DATA_WIDTH = 32;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

`ifdef SIMULATION
  // Named event counters for profiling runs.
  int unsigned stats_table [string];

  function automatic void stats_event(input string name);
    if (stats_table.exists(name)) stats_table[name] = stats_table[name] + 1;
    else                          stats_table[name] = 1;
  endfunction
`endif

endpackage

// File: rtl/fetch_buffer.sv
// Instruction queue between I-cache output and decode.
// Absorbs decode stalls, raises front_pipeline_halt when full, and counts
// instructions discarded by flushes.
module fetch_buffer
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH      = FETCH_BUF_DEPTH,
  parameter int unsigned ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [DATA_WIDTH-1:0]      in_instr,
  output logic                       in_ready,
  input  logic                       dec_stall,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_instr,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       front_pipeline_halt,
  output logic [CNT_WIDTH-1:0]       drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  fetch_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [OCC_W-1:0]     occ;
  logic                 full;
  logic                 enq;
  logic                 deq;
  logic [CNT_WIDTH:0]   drop_sum;
  fetch_entry_t         head_entry;

  // Handshake decode; flush suppresses both sides of the queue.
  always_comb begin
    full      = (occ == FULL_OCC);
    in_ready  = ~full;
    out_valid = (occ != '0);
    enq       = in_valid & ~full & ~flush;
    deq       = out_valid & ~dec_stall & ~flush;
    front_pipeline_halt = full;
    occupancy = occ;
  end

  // Head entry presented to decode, forced to zero when the queue is empty.
  always_comb begin
    head_entry = mem[head];
    out_pc     = '0;
    out_instr  = '0;
    if (out_valid) begin
      out_pc    = ADDR_WIDTH'(head_entry.pc);
      out_instr = DATA_WIDTH'(head_entry.instr);
    end
  end

  // Drop-counter increment: everything held plus the same-cycle input.
  // One extra bit catches overflow for saturation.
  always_comb begin
    drop_sum = {1'b0, drop_count}
             + (CNT_WIDTH+1)'(occ)
             + (CNT_WIDTH+1)'(in_valid);
  end

  // Pointer, occupancy and drop-counter state; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      occ        <= '0;
      drop_count <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      occ        <= '0;
      drop_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage: written only at tail on enqueue, never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && enq) begin
      mem[tail].pc    <= FETCH_ADDR_WIDTH'(in_pc);
      mem[tail].instr <= FETCH_DATA_WIDTH'(in_instr);
    end
  end

`ifdef SIMULATION
  // Profiling: one event per cycle spent full.
  always @(posedge clk) begin
    if (rst_n && front_pipeline_halt) stats_event("fetch_buf_full");
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OW    = $clog2(DEPTH) + 1;
  localparam int unsigned MAXD  = 65535;
  localparam int unsigned MAXS  = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        dec_stall = 1'b0;
  logic        flush = 1'b0;

  logic          in_ready, out_valid, front_pipeline_halt;
  logic [31:0]   out_pc, out_instr;
  logic [OW-1:0] occupancy;
  logic [15:0]   drop_count;

  logic          s_in_ready, s_out_valid, s_halt;
  logic [31:0]   s_out_pc, s_out_instr;
  logic [OW-1:0] s_occupancy;
  logic [3:0]    s_drop_count;

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .dec_stall(dec_stall), .flush(flush), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .occupancy(occupancy),
    .front_pipeline_halt(front_pipeline_halt), .drop_count(drop_count)
  );

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(s_in_ready), .dec_stall(dec_stall), .flush(flush), .out_valid(s_out_valid),
    .out_pc(s_out_pc), .out_instr(s_out_instr), .occupancy(s_occupancy),
    .front_pipeline_halt(s_halt), .drop_count(s_drop_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ment_t;
  ment_t       mq[$];
  int unsigned m_drop = 0;
  int unsigned m_drop_s = 0;
  logic [31:0] got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a queue of at most DEPTH entries.
  task automatic model_step(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                            input bit st, input bit fl, input bit rs);
    int unsigned n;
    bit was_full;
    if (rs) begin
      mq.delete();
      m_drop = 0;
      m_drop_s = 0;
    end else if (fl) begin
      n = mq.size() + (iv ? 1 : 0);
      m_drop   = (m_drop + n > MAXD) ? MAXD : m_drop + n;
      m_drop_s = (m_drop_s + n > MAXS) ? MAXS : m_drop_s + n;
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      if (mq.size() != 0 && !st) void'(mq.pop_front());
      if (iv && !was_full) mq.push_back('{pc, ins});
    end
  endtask

  task automatic check_model();
    logic [31:0] epc, ein;
    epc = (mq.size() != 0) ? mq[0].pc : 32'h0;
    ein = (mq.size() != 0) ? mq[0].instr : 32'h0;
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("out_pc", 64'(out_pc), 64'(epc));
    chk("out_instr", 64'(out_instr), 64'(ein));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    chk("halt", 64'(front_pipeline_halt), 64'(mq.size() == DEPTH));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("sat_drop_count", 64'(s_drop_count), 64'(m_drop_s));
  endtask

  // One clock: drive inputs, note any consumed head, clock, then check.
  task automatic cycle(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                       input bit st, input bit fl, input bit rs);
    in_valid = iv; in_pc = pc; in_instr = ins; dec_stall = st; flush = fl; rst_n = ~rs;
    #1;
    if (!rs && !fl && out_valid && !st) got.push_back(out_pc);
    @(posedge clk);
    model_step(iv, pc, ins, st, fl, rs);
    #1;
    check_model();
  endtask

  typedef struct {
    bit          iv;
    logic [31:0] pc;
    bit          st;
    int unsigned occ;
    bit          vld;
    logic [31:0] opc;
    bit          rdy;
    bit          halt;
  } vec_t;

  vec_t tbl[11];
  logic [31:0] p;
  int unsigned saved;

  initial begin
    // Fill with stall, refuse when full, no pass-through when full, drain in order.
    tbl[0]  = '{1'b1, 32'h100, 1'b1, 1, 1'b1, 32'h100, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'h104, 1'b1, 2, 1'b1, 32'h100, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'h108, 1'b1, 3, 1'b1, 32'h100, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'h10C, 1'b1, 4, 1'b1, 32'h100, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 32'h110, 1'b1, 4, 1'b1, 32'h100, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 32'h114, 1'b0, 3, 1'b1, 32'h104, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,   1'b0, 2, 1'b1, 32'h108, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,   1'b0, 1, 1'b1, 32'h10C, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,   1'b0, 0, 1'b0, 32'h0,   1'b1, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h0,   1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h0,   1'b0, 0, 1'b0, 32'h0,   1'b1, 1'b0};

    // Reset state.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_halt", 64'(front_pipeline_halt), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].iv, tbl[i].pc, ~tbl[i].pc, tbl[i].st, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_pc", i), 64'(out_pc), 64'(tbl[i].opc));
      chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_halt", i), 64'(front_pipeline_halt), 64'(tbl[i].halt));
    end

    // Streaming: one in, one out per cycle after the first.
    for (int i = 0; i < 8; i++) begin
      p = 32'h400 + 32'(4 * i);
      cycle(1'b1, p, ~p, 1'b0, 1'b0, 1'b0);
      chk("stream_occ", 64'(occupancy), 64'd1);
      chk("stream_pc", 64'(out_pc), 64'(p));
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Wrap: ten enqueues interleaved with dequeues, then drain.
    got.delete();
    for (int i = 0; i < 10; i++) begin
      p = 32'h500 + 32'(4 * i);
      cycle(1'b1, p, ~p, (i % 4) == 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("wrap_count", 64'(got.size()), 64'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk($sformatf("wrap_pc%0d", i), 64'(got[i]), 64'(32'h500 + 32'(4 * i)));

    // Flush with three held plus a same-cycle input.
    for (int i = 0; i < 3; i++) begin
      p = 32'h210 + 32'(4 * i);
      cycle(1'b1, p, ~p, 1'b1, 1'b0, 1'b0);
    end
    chk("preflush_occ", 64'(occupancy), 64'd3);
    saved = drop_count;
    cycle(1'b1, 32'h200, 32'hDEAD_0200, 1'b0, 1'b1, 1'b0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_drop", 64'(drop_count), 64'(saved + 4));
    cycle(1'b1, 32'h300, 32'hBEEF_0300, 1'b1, 1'b0, 1'b0);
    chk("postflush_pc", 64'(out_pc), 64'h300);
    chk("postflush_occ", 64'(occupancy), 64'd1);

    // Reset mid-stream with two held; reset wins over flush.
    cycle(1'b1, 32'h304, 32'hBEEF_0304, 1'b1, 1'b0, 1'b0);
    chk("prerst_occ", 64'(occupancy), 64'd2);
    cycle(1'b1, 32'h308, 32'hBEEF_0308, 1'b0, 1'b1, 1'b1);
    chk("midrst_occ", 64'(occupancy), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_pc", 64'(out_pc), 64'd0);
    chk("midrst_instr", 64'(out_instr), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_halt", 64'(front_pipeline_halt), 64'd0);
    chk("midrst_drop", 64'(drop_count), 64'd0);
    cycle(1'b1, 32'h600, 32'hCAFE_0600, 1'b1, 1'b0, 1'b0);
    chk("resume_occ", 64'(occupancy), 64'd1);
    chk("resume_pc", 64'(out_pc), 64'h600);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    // Saturation of the narrow counter: four full flushes of five each.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        p = 32'h700 + 32'(4 * i);
        cycle(1'b1, p, ~p, 1'b1, 1'b0, 1'b0);
      end
      cycle(1'b1, 32'h7F0, 32'h0, 1'b1, 1'b1, 1'b0);
    end
    chk("sat_drop_final", 64'(s_drop_count), 64'd15);
    chk("wide_drop_final", 64'(drop_count), 64'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
